// File: rtl/inst_sequencer.sv
// Loadable program player: plays a small writable instruction store onto INST,
// presenting each word for HOLD clocks. Define INST_SEQ_LOOP_EN to replay the program forever.
module inst_sequencer #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned HOLD   = 5
) (
    input  logic              ck,
    input  logic              res,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic [ADDR_W:0]   len,
    input  logic              start,
    input  logic              stall,
    output logic [15:0]       INST,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [7:0] HoldReload = 8'(HOLD - 1);
    localparam logic [ADDR_W-1:0] PcOne = 1;
    localparam logic [ADDR_W:0] LenOne = 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       inst_q, inst_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              done_q, done_d;

    logic [15:0]       mem [Depth];
    logic              mem_we;
    logic [15:0]       word0;
    logic [ADDR_W-1:0] pc_inc;
    logic              last_word;

    assign mem_we = wr_en && (state_q != StIssue);

    // Store is deliberately not reset so a program survives res.
    always_ff @(posedge ck) begin
        if (mem_we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A write to address 0 in the start cycle must land on INST at issue.
    assign word0     = (mem_we && (wr_addr == '0)) ? wr_data : mem[0];
    assign pc_inc    = pc_q + PcOne;
    assign last_word = ({1'b0, pc_q} == (len_q - LenOne));

    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            state_q <= StIdle;
            pc_q    <= '0;
            inst_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = done_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start && (len != '0)) begin
                    state_d = StIssue;
                    len_d   = len;
                    pc_d    = '0;
                    inst_d  = word0;
                    cnt_d   = HoldReload;
                    done_d  = 1'b0;
                end
            end
            StIssue: begin
                if (!stall) begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else if (!last_word) begin
                        pc_d   = pc_inc;
                        inst_d = mem[pc_inc];
                        cnt_d  = HoldReload;
                    end else begin
`ifdef INST_SEQ_LOOP_EN
                        pc_d   = '0;
                        inst_d = mem[0];
                        cnt_d  = HoldReload;
`else
                        state_d = StDone;
                        inst_d  = '0;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign INST       = inst_q;
    assign inst_valid = (state_q == StIssue);
    assign busy       = (state_q == StIssue);
    assign pc         = pc_q;
    assign done       = done_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer: stimulus queues expected {pc, INST} per presented
// clock and a negedge monitor pops and compares whenever inst_valid is high.
module tb_inst_sequencer;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;
`ifdef INST_SEQ_LOOP_EN
    localparam int unsigned HOLD = 1;
`else
    localparam int unsigned HOLD = 5;
`endif

    logic              ck = 1'b0;
    logic              res = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [15:0]       wr_data = '0;
    logic [ADDR_W:0]   len = '0;
    logic              start = 1'b0;
    logic              stall = 1'b0;
    logic [15:0]       INST;
    logic              inst_valid;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              done;

    inst_sequencer #(.ADDR_W(ADDR_W), .HOLD(HOLD)) dut (
        .ck(ck), .res(res), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .start(start), .stall(stall), .INST(INST), .inst_valid(inst_valid),
        .pc(pc), .busy(busy), .done(done)
    );

    always #5 ck = ~ck;

    int          checks = 0;
    int          errors = 0;
    int          busy_cycles = 0;
    logic [19:0] exp_q[$];
    logic [15:0] mem_m [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected entry per clock that INST carries a word.
    always @(negedge ck) begin
        if (res && inst_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got pc=%0d INST=%h expected none", pc, INST);
            end else begin
                check("word", {12'h0, pc, INST}, {12'h0, exp_q.pop_front()});
            end
        end
        if (res && busy) busy_cycles++;
    end

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic write(input int a, input logic [15:0] d, input bit stored);
        wr_en = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (stored) mem_m[a] = d;
    endtask

    task automatic push_program(input int n, input int stall_word, input int extra);
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < HOLD + ((w == stall_word) ? extra : 0); k++) begin
                exp_q.push_back({ADDR_W'(w), mem_m[w]});
            end
        end
    endtask

    task automatic do_start(input int l);
        len = (ADDR_W + 1)'(l);
        start = 1'b1;
        busy_cycles = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_busy, input int exp_pc);
        int n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        check("done_set", {31'h0, done}, 32'h1);
        check("busy_clear", {31'h0, busy}, 32'h0);
        check("valid_clear", {31'h0, inst_valid}, 32'h0);
        check("inst_zero", {16'h0, INST}, 32'h0);
        check("pc_last", {28'h0, pc}, exp_pc);
        check("busy_cycles", busy_cycles, exp_busy);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_inst"}, {16'h0, INST}, 32'h0);
        check({tag, "_valid"}, {31'h0, inst_valid}, 32'h0);
        check({tag, "_pc"}, {28'h0, pc}, 32'h0);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_done"}, {31'h0, done}, 32'h0);
    endtask

    initial begin
        #12;
        check_reset_outputs("reset");
        res = 1'b1;
        tick();

        write(0, 16'h1205, 1'b1);
        write(1, 16'h1403, 1'b1);
        write(2, 16'h0650, 1'b1);
        write(3, 16'h26C8, 1'b1);

`ifdef INST_SEQ_LOOP_EN
        for (int k = 0; k < 6; k++) exp_q.push_back({ADDR_W'(k % 2), mem_m[k % 2]});
        do_start(2);
        repeat (6) tick();
        check("loop_done_low", {31'h0, done}, 32'h0);
        check("loop_busy_high", {31'h0, busy}, 32'h1);
        check("loop_drained", exp_q.size(), 0);
        res = 1'b0;
        #1;
        check_reset_outputs("loop_reset");
        res = 1'b1;
`else
        for (int a = 4; a < DEPTH; a++) write(a, 16'hA000 + 16'(a), 1'b1);

        // len=0 from IDLE: nothing happens
        do_start(0);
        tick();
        check("len0_idle_valid", {31'h0, inst_valid}, 32'h0);
        check("len0_idle_done", {31'h0, done}, 32'h0);

        push_program(4, -1, 0);
        do_start(4);
        wait_done(20, 3);

        // len=0 from DONE: done stays sticky
        do_start(0);
        tick();
        check("len0_done_done", {31'h0, done}, 32'h1);
        check("len0_done_valid", {31'h0, inst_valid}, 32'h0);
        check("len0_done_pc", {28'h0, pc}, 32'h3);

        // stall 3 clocks inside word 1
        push_program(4, 1, 3);
        do_start(4);
        repeat (6) tick();
        stall = 1'b1;
        repeat (3) tick();
        stall = 1'b0;
        wait_done(23, 3);

        // async reset during word 2
        push_program(2, -1, 0);
        exp_q.push_back({4'd2, mem_m[2]});
        exp_q.push_back({4'd2, mem_m[2]});
        do_start(4);
        repeat (12) tick();
        #1 res = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        check("mid_reset_drained", exp_q.size(), 0);
        #1 res = 1'b1;
        tick();

        push_program(4, -1, 0);
        do_start(4);
        check("replay_first", {16'h0, INST}, 32'h1205);
        wait_done(20, 3);

        // write during ISSUE is ignored
        push_program(4, -1, 0);
        do_start(4);
        tick();
        write(2, 16'hFFFF, 1'b0);
        wait_done(20, 3);

        // same write in DONE takes effect
        write(2, 16'hFFFF, 1'b1);
        push_program(4, -1, 0);
        do_start(4);
        wait_done(20, 3);

        // write to address 0 in the start cycle is seen at issue
        mem_m[0] = 16'hABCD;
        push_program(4, -1, 0);
        wr_en = 1'b1;
        wr_addr = '0;
        wr_data = 16'hABCD;
        do_start(4);
        wr_en = 1'b0;
        wait_done(20, 3);

        // full depth, each word exactly once
        push_program(DEPTH, -1, 0);
        do_start(DEPTH);
        wait_done(DEPTH * HOLD, DEPTH - 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
- Instruction source for the CPU1 instruction input.
- Holds a small writable program store and sequences its words onto a 16-bit INST bus.
- Presents each word for a fixed number of clocks so the CPU pipeline can complete it.
- Replaces hand-timed instruction driving with a loadable, restartable program player.

Parameters:
- ADDR_W, 4, program store address width; depth = 2**ADDR_W words.
- HOLD, 5, clocks each instruction is presented on INST (legal 1..255).

Ports:
- ck  input  1  clock, rising-edge.
- res  input  1  reset, asynchronous, active-low.
- wr_en  input  1  program store write strobe.
- wr_addr  input  ADDR_W  program store write address.
- wr_data  input  16  instruction word to store.
- len  input  ADDR_W+1  program length in words (0..depth); sampled on accepted start.
- start  input  1  begin issuing from address 0.
- stall  input  1  freeze the current instruction and hold count.
- INST  output  16  instruction presented to the CPU.
- inst_valid  output  1  INST carries a program word.
- pc  output  ADDR_W  address of the word on INST.
- busy  output  1  sequence in progress.
- done  output  1  sequence completed; sticky until next start or reset.

Behaviour:
- Reset (res=0, asynchronous):
  - INST=16'h0000, inst_valid=0, pc=0, busy=0, done=0.
  - State=IDLE, hold counter=0, latched length=0.
  - Program store contents are not reset.
- States: IDLE, ISSUE, DONE.
- Writes:
  - In IDLE or DONE, wr_en=1 writes wr_data to mem[wr_addr] on the clock edge.
  - In ISSUE, wr_en is ignored.
- IDLE/DONE with start=1 and len!=0:
  - Next edge: latch len, pc=0, INST=mem[0], inst_valid=1, busy=1, done=0.
  - Hold counter=HOLD-1; state=ISSUE.
- start with len=0: ignored; state, outputs and done are unchanged.
- Write and start in the same cycle: the write happens first. A write to address 0 is visible on INST at issue.
- ISSUE, stall=1: all registers hold.
- ISSUE, stall=0, hold counter!=0: decrement the counter.
- ISSUE, stall=0, hold counter=0, pc!=len-1:
  - pc=pc+1, INST=mem[pc+1], counter reloads to HOLD-1.
- ISSUE, stall=0, hold counter=0, pc=len-1:
  - State=DONE, inst_valid=0, INST=16'h0000, busy=0, done=1. pc holds its last value.
- Timing with no stalls:
  - Each word is on INST for exactly HOLD consecutive clocks.
  - Total busy time is len*HOLD clocks.
- start during ISSUE: ignored.
- pc wraps only via the Optional Feature; len=depth issues mem[0..depth-1] exactly once.
- Reset mid-ISSUE: outputs return to reset values immediately. Memory is retained, so a later start replays the program.
- INST changes only on clock edges and is registered; there is no combinational path from any input to INST.

Optional Feature:
- Macro: INST_SEQ_LOOP_EN.
- Defined: on reaching the last word (hold counter=0, pc=len-1, stall=0):
  - pc wraps to 0, INST=mem[0], counter reloads to HOLD-1; state stays ISSUE.
  - done is never set; busy stays 1.
  - A new start is required to change length, and it is accepted only after reset.
- Undefined: behaviour exactly as described above; the sequence terminates in DONE.

Test Plan:
- Load mem[0..3]={16'h1205,16'h1403,16'h0650,16'h26C8}, len=4, HOLD=5, start pulse -> INST shows each word for exactly 5 clocks in order, pc 0..3, inst_valid=1 for 20 clocks, then done=1, busy=0, INST=0000.
- Same program, stall=1 for 3 clocks during word 1 -> word 1 is held for 8 clocks, all other words for 5; total busy time 23 clocks.
- len=0 with start -> no state change, inst_valid stays 0, done stays at its prior value.
- Drive res=0 for one cycle midway through word 2 -> all outputs return to 0 asynchronously; a fresh start replays from mem[0]=1205.
- wr_en to address 2 with data FFFF during ISSUE -> store unchanged, word 2 still 0650; the same write in DONE followed by start -> word 2 becomes FFFF.
- With INST_SEQ_LOOP_EN defined, len=2, HOLD=1 -> INST alternates 1205,1403,1205,... every clock, done never asserts.
